// File: rtl/rv32i_ctrl_exec.sv
// RV32I decode, execute and pipeline-control block for a 5-stage in-order core.
// Pipeline registers, register file and memories live outside this module.
module rv32i_ctrl_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     id_instr,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [31:0]     id_imm,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic [6:0]      ex_funct7,
  input  logic [4:0]      ex_rd,
  input  logic [4:0]      ex_rs1,
  input  logic [4:0]      ex_rs2,
  input  logic [XLEN-1:0] ex_rs1_data,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [6:0]      mem_opcode,
  input  logic [2:0]      mem_funct3,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic [6:0]      wb_opcode,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] ex_result,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] branch_target,
  output logic            branch_taken,
  output logic [1:0]      fetch_sel,
  output logic            nop_fetch,
  output logic            nop_dec,
  output logic            mem_store,
  output logic            mem_load,
  output logic [2:0]      mem_size,
  output logic            mem_sign,
  output logic            reg_wen,
  output logic [31:0]     instret
);

  localparam logic [6:0] OPC_LUI   = 7'h37;
  localparam logic [6:0] OPC_AUIPC = 7'h17;
  localparam logic [6:0] OPC_JAL   = 7'h6F;
  localparam logic [6:0] OPC_JALR  = 7'h67;
  localparam logic [6:0] OPC_BR    = 7'h63;
  localparam logic [6:0] OPC_LD    = 7'h03;
  localparam logic [6:0] OPC_ST    = 7'h23;
  localparam logic [6:0] OPC_OPI   = 7'h13;
  localparam logic [6:0] OPC_OP    = 7'h33;

  localparam logic [1:0] SEL_PC     = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_REPLAY = 2'b10;

  function automatic logic is_writer(input logic [6:0] op);
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LD, OPC_OPI, OPC_OP: is_writer = 1'b1;
      default: is_writer = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] size_of(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   size_of = 3'b001;
      2'b01:   size_of = 3'b010;
      2'b10:   size_of = 3'b100;
      default: size_of = 3'b000;
    endcase
  endfunction

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] alu_b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] sra_val;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] jalr_sum;
  logic            br_cond;
  logic            taken;
  logic            id_uses_rs1;
  logic            id_uses_rs2;
  logic            load_use;
  logic [31:0]     instret_d;
  logic [31:0]     instret_q;
  logic            ex_funct7_unused;

  assign ex_funct7_unused = ^{ex_funct7[6], ex_funct7[4:0]};

  // Field extraction and immediate generation for the IF/ID instruction.
  always_comb begin
    id_opcode = id_instr[6:0];
    id_rd     = id_instr[11:7];
    id_funct3 = id_instr[14:12];
    id_rs1    = id_instr[19:15];
    id_rs2    = id_instr[24:20];
    id_funct7 = id_instr[31:25];
    case (id_instr[6:0])
      OPC_JALR, OPC_LD, OPC_OPI:
        id_imm = {{20{id_instr[31]}}, id_instr[31:20]};
      OPC_ST:
        id_imm = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
      OPC_BR:
        id_imm = {{19{id_instr[31]}}, id_instr[31], id_instr[7], id_instr[30:25],
                  id_instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        id_imm = {id_instr[31:12], 12'h000};
      OPC_JAL:
        id_imm = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12], id_instr[20],
                  id_instr[30:21], 1'b0};
      default:
        id_imm = 32'h0000_0000;
    endcase
  end

  // Operand forwarding: the younger MEM-stage writer wins over WB; x0 never forwards.
  always_comb begin
    if ((ex_rs1 != 5'd0) && is_writer(mem_opcode) && (mem_rd == ex_rs1)) begin
      rs1_fwd = mem_result;
    end else if ((ex_rs1 != 5'd0) && is_writer(wb_opcode) && (wb_rd == ex_rs1)) begin
      rs1_fwd = wb_data;
    end else begin
      rs1_fwd = ex_rs1_data;
    end
    if ((ex_rs2 != 5'd0) && is_writer(mem_opcode) && (mem_rd == ex_rs2)) begin
      rs2_fwd = mem_result;
    end else if ((ex_rs2 != 5'd0) && is_writer(wb_opcode) && (wb_rd == ex_rs2)) begin
      rs2_fwd = wb_data;
    end else begin
      rs2_fwd = ex_rs2_data;
    end
  end

  assign sra_val = $signed(rs1_fwd) >>> shamt;

  // Integer ALU; funct7[5] selects SUB only for register-register ops.
  always_comb begin
    alu_b = (ex_opcode == OPC_OPI) ? ex_imm : rs2_fwd;
    shamt = alu_b[4:0];
    case (ex_funct3)
      3'b000: begin
        if ((ex_opcode == OPC_OP) && ex_funct7[5]) begin
          alu_out = rs1_fwd - alu_b;
        end else begin
          alu_out = rs1_fwd + alu_b;
        end
      end
      3'b001: alu_out = rs1_fwd << shamt;
      3'b010: alu_out = {{(XLEN-1){1'b0}}, ($signed(rs1_fwd) < $signed(alu_b))};
      3'b011: alu_out = {{(XLEN-1){1'b0}}, (rs1_fwd < alu_b)};
      3'b100: alu_out = rs1_fwd ^ alu_b;
      3'b101: begin
        if (ex_funct7[5]) begin
          alu_out = sra_val;
        end else begin
          alu_out = rs1_fwd >> shamt;
        end
      end
      3'b110: alu_out = rs1_fwd | alu_b;
      3'b111: alu_out = rs1_fwd & alu_b;
      default: alu_out = {XLEN{1'b0}};
    endcase
  end

  // Execute-stage result mux and store-data output.
  always_comb begin
    ex_store_data = rs2_fwd;
    case (ex_opcode)
      OPC_LUI:           ex_result = ex_imm;
      OPC_AUIPC:         ex_result = ex_pc + ex_imm;
      OPC_JAL, OPC_JALR: ex_result = ex_pc + XLEN'(4);
      OPC_LD, OPC_ST:    ex_result = rs1_fwd + ex_imm;
      OPC_OPI, OPC_OP:   ex_result = alu_out;
      default:           ex_result = {XLEN{1'b0}};
    endcase
  end

  // Branch condition, redirect decision and target.
  always_comb begin
    jalr_sum = rs1_fwd + ex_imm;
    case (ex_funct3)
      3'b000:  br_cond = (rs1_fwd == rs2_fwd);
      3'b001:  br_cond = (rs1_fwd != rs2_fwd);
      3'b100:  br_cond = ($signed(rs1_fwd) < $signed(rs2_fwd));
      3'b101:  br_cond = ($signed(rs1_fwd) >= $signed(rs2_fwd));
      3'b110:  br_cond = (rs1_fwd < rs2_fwd);
      3'b111:  br_cond = (rs1_fwd >= rs2_fwd);
      default: br_cond = 1'b0;
    endcase
    case (ex_opcode)
      OPC_BR: begin
        taken         = br_cond;
        branch_target = ex_pc + ex_imm;
      end
      OPC_JAL: begin
        taken         = 1'b1;
        branch_target = ex_pc + ex_imm;
      end
      OPC_JALR: begin
        taken         = 1'b1;
        branch_target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default: begin
        taken         = 1'b0;
        branch_target = ex_pc + ex_imm;
      end
    endcase
  end

  // Load-use detection against the instruction waiting in decode.
  always_comb begin
    case (id_opcode)
      7'h00, OPC_LUI, OPC_AUIPC, OPC_JAL: id_uses_rs1 = 1'b0;
      default:                            id_uses_rs1 = 1'b1;
    endcase
    case (id_opcode)
      OPC_BR, OPC_ST, OPC_OP: id_uses_rs2 = 1'b1;
      default:                id_uses_rs2 = 1'b0;
    endcase
    load_use = (ex_opcode == OPC_LD) && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (ex_rd == id_rs1)) || (id_uses_rs2 && (ex_rd == id_rs2)));
  end

  // Fetch steering and flush/bubble control; reset forces the safe state.
  always_comb begin
    if (rst) begin
      branch_taken = 1'b0;
      fetch_sel    = SEL_PC;
      nop_fetch    = 1'b1;
      nop_dec      = 1'b1;
    end else if (taken) begin
      branch_taken = 1'b1;
      fetch_sel    = SEL_BRANCH;
      nop_fetch    = 1'b1;
      nop_dec      = 1'b1;
    end else if (load_use) begin
      branch_taken = 1'b0;
      fetch_sel    = SEL_REPLAY;
      nop_fetch    = 1'b0;
      nop_dec      = 1'b1;
    end else begin
      branch_taken = 1'b0;
      fetch_sel    = SEL_PC;
      nop_fetch    = 1'b0;
      nop_dec      = 1'b0;
    end
  end

  // Data-memory controls from MEM stage and regfile write enable from WB stage.
  always_comb begin
    mem_size = size_of(mem_funct3[1:0]);
    mem_sign = ~mem_funct3[2];
    if (rst) begin
      mem_load  = 1'b0;
      mem_store = 1'b0;
      reg_wen   = 1'b0;
    end else begin
      mem_load  = (mem_opcode == OPC_LD);
      mem_store = (mem_opcode == OPC_ST);
      reg_wen   = is_writer(wb_opcode) && (wb_rd != 5'd0);
    end
  end

  // Retired-instruction count; wraps naturally at 2^32.
  always_comb begin
    if (wb_opcode != 7'h00) begin
      instret_d = instret_q + 32'd1;
    end else begin
      instret_d = instret_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= 32'd0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_rv32i_ctrl_exec.sv
// Directed self-checking bench for rv32i_ctrl_exec: decode, forwarding, ALU,
// branches, load-use replay, memory controls and the retirement counter.
module tb_rv32i_ctrl_exec;

  logic        clk;
  logic        rst;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic [31:0] id_imm;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic [6:0]  mem_opcode;
  logic [2:0]  mem_funct3;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic [6:0]  wb_opcode;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] ex_result, ex_store_data, branch_target;
  logic        branch_taken;
  logic [1:0]  fetch_sel;
  logic        nop_fetch, nop_dec, mem_store, mem_load, mem_sign, reg_wen;
  logic [2:0]  mem_size;
  logic [31:0] instret;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  rv32i_ctrl_exec #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .id_instr(id_instr),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .mem_opcode(mem_opcode), .mem_funct3(mem_funct3), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_opcode(wb_opcode), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_result(ex_result), .ex_store_data(ex_store_data),
    .branch_target(branch_target), .branch_taken(branch_taken),
    .fetch_sel(fetch_sel), .nop_fetch(nop_fetch), .nop_dec(nop_dec),
    .mem_store(mem_store), .mem_load(mem_load), .mem_size(mem_size), .mem_sign(mem_sign),
    .reg_wen(reg_wen), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_stages();
    id_instr = 32'h0;
    ex_opcode = 7'h0; ex_funct3 = 3'h0; ex_funct7 = 7'h0;
    ex_rd = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
    ex_rs1_data = 32'h0; ex_rs2_data = 32'h0; ex_imm = 32'h0; ex_pc = 32'h0;
    mem_opcode = 7'h0; mem_funct3 = 3'h0; mem_rd = 5'd0; mem_result = 32'h0;
    wb_opcode = 7'h0; wb_rd = 5'd0; wb_data = 32'h0;
  endtask

  task automatic set_ex(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [31:0] pc);
    ex_opcode = op; ex_funct3 = f3; ex_funct7 = f7;
    ex_rd = rd; ex_rs1 = rs1; ex_rs2 = rs2;
    ex_rs1_data = d1; ex_rs2_data = d2; ex_imm = imm; ex_pc = pc;
  endtask

  initial begin
    rst = 1'b1;
    clear_stages();
    mem_opcode = 7'h03; wb_opcode = 7'h33; wb_rd = 5'd1;
    repeat (2) @(negedge clk);
    chk("rst_instret",   instret, 32'd0);
    chk("rst_fetch_sel", {30'd0, fetch_sel}, 32'd0);
    chk("rst_nops",      {30'd0, nop_fetch, nop_dec}, 32'd3);
    chk("rst_mem_load",  {31'd0, mem_load}, 32'd0);
    chk("rst_reg_wen",   {31'd0, reg_wen}, 32'd0);

    // Seven retirements, then idle.
    clear_stages();
    rst = 1'b0;
    wb_opcode = 7'h33;
    repeat (7) @(negedge clk);
    wb_opcode = 7'h00;
    chk("instret_7", instret, 32'd7);
    @(negedge clk);
    chk("instret_hold", instret, 32'd7);

    // Reset held two cycles with a taken branch present in EX.
    set_ex(7'h63, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'd7, 32'd7, 32'hFFFF_FFF8, 32'h100);
    mem_opcode = 7'h23; wb_opcode = 7'h13; wb_rd = 5'd4;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst2_instret", instret, 32'd0);
    chk("rst2_taken",   {31'd0, branch_taken}, 32'd0);
    chk("rst2_fsel",    {30'd0, fetch_sel}, 32'd0);
    chk("rst2_nops",    {30'd0, nop_fetch, nop_dec}, 32'd3);
    chk("rst2_store",   {31'd0, mem_store}, 32'd0);
    chk("rst2_reg_wen", {31'd0, reg_wen}, 32'd0);
    rst = 1'b0;
    clear_stages();
    @(negedge clk);

    // Decode.
    id_instr = 32'h0050_0093; #1;
    chk("dec_addi_op",  {25'd0, id_opcode}, 32'h13);
    chk("dec_addi_rd",  {27'd0, id_rd}, 32'd1);
    chk("dec_addi_imm", id_imm, 32'd5);
    id_instr = 32'hFE21_AE23; #1;
    chk("dec_sw_imm",   id_imm, 32'hFFFF_FFFC);
    chk("dec_sw_rs",    {22'd0, id_rs1, id_rs2}, {22'd0, 5'd3, 5'd2});
    chk("dec_sw_f3",    {29'd0, id_funct3}, 32'd2);
    id_instr = 32'hFE00_0CE3; #1;
    chk("dec_beq_imm",  id_imm, 32'hFFFF_FFF8);
    id_instr = 32'h0010_00EF; #1;
    chk("dec_jal_imm",  id_imm, 32'h0000_0800);
    id_instr = 32'h1234_52B7; #1;
    chk("dec_lui_imm",  id_imm, 32'h1234_5000);
    id_instr = 32'h0000_0000; #1;
    chk("dec_bubble_imm", id_imm, 32'h0);

    // Forwarding.
    mem_opcode = 7'h13; mem_rd = 5'd1; mem_result = 32'd5;
    wb_opcode = 7'h33; wb_rd = 5'd1; wb_data = 32'd7;
    set_ex(7'h33, 3'b000, 7'h00, 5'd2, 5'd1, 5'd1, 32'hDEAD, 32'hBEEF, 32'h0, 32'h0); #1;
    chk("fwd_mem", ex_result, 32'd10);
    mem_opcode = 7'h23; #1;
    chk("fwd_wb", ex_result, 32'd14);
    chk("fwd_wb_store", ex_store_data, 32'd7);
    mem_opcode = 7'h13; mem_rd = 5'd0; mem_result = 32'd99; wb_rd = 5'd0;
    set_ex(7'h33, 3'b000, 7'h00, 5'd2, 5'd0, 5'd0, 32'd3, 32'd4, 32'h0, 32'h0); #1;
    chk("fwd_x0", ex_result, 32'd7);
    clear_stages();

    // ALU.
    set_ex(7'h33, 3'b000, 7'h20, 5'd1, 5'd2, 5'd3, 32'd3, 32'd5, 32'h0, 32'h0); #1;
    chk("alu_sub", ex_result, 32'hFFFF_FFFE);
    set_ex(7'h33, 3'b101, 7'h20, 5'd1, 5'd2, 5'd3, 32'hFFFF_FF00, 32'd4, 32'h0, 32'h0); #1;
    chk("alu_sra", ex_result, 32'hFFFF_FFF0);
    ex_funct7 = 7'h00; #1;
    chk("alu_srl", ex_result, 32'h0FFF_FFF0);
    set_ex(7'h13, 3'b010, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'd1, 32'h0); #1;
    chk("alu_slti", ex_result, 32'd1);
    set_ex(7'h33, 3'b011, 7'h00, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0); #1;
    chk("alu_sltu", ex_result, 32'd0);
    set_ex(7'h13, 3'b001, 7'h01, 5'd1, 5'd2, 5'd0, 32'd1, 32'h0, 32'h24, 32'h0); #1;
    chk("alu_slli", ex_result, 32'h10);
    set_ex(7'h13, 3'b000, 7'h20, 5'd1, 5'd2, 5'd0, 32'd10, 32'h0, 32'h400, 32'h0); #1;
    chk("alu_addi_f7", ex_result, 32'h40A);
    set_ex(7'h17, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h1234_5000, 32'h1000); #1;
    chk("alu_auipc", ex_result, 32'h1234_6000);

    // Branches.
    set_ex(7'h63, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'd7, 32'd7, 32'hFFFF_FFF8, 32'h100); #1;
    chk("beq_taken",  {31'd0, branch_taken}, 32'd1);
    chk("beq_target", branch_target, 32'hF8);
    chk("beq_fsel",   {30'd0, fetch_sel}, 32'd1);
    chk("beq_nops",   {30'd0, nop_fetch, nop_dec}, 32'd3);
    ex_funct3 = 3'b001; #1;
    chk("bne_eq_not", {29'd0, branch_taken, fetch_sel}, 32'd0);
    ex_funct3 = 3'b100; ex_rs1_data = 32'hFFFF_FFFF; ex_rs2_data = 32'd1; #1;
    chk("blt_taken", {31'd0, branch_taken}, 32'd1);
    ex_funct3 = 3'b110; #1;
    chk("bltu_not", {31'd0, branch_taken}, 32'd0);
    ex_funct3 = 3'b010; #1;
    chk("br_bad_f3", {30'd0, nop_fetch, nop_dec}, 32'd0);
    set_ex(7'h67, 3'b000, 7'h00, 5'd0, 5'd3, 5'd0, 32'h203, 32'h0, 32'd4, 32'h40);
    wb_opcode = 7'h67; wb_rd = 5'd0; #1;
    chk("jalr_target", branch_target, 32'h206);
    chk("jalr_result", ex_result, 32'h44);
    chk("jalr_taken",  {31'd0, branch_taken}, 32'd1);
    chk("wen_x0",      {31'd0, reg_wen}, 32'd0);
    wb_rd = 5'd3; #1;
    chk("wen_x3",      {31'd0, reg_wen}, 32'd1);
    wb_opcode = 7'h63; #1;
    chk("wen_branch",  {31'd0, reg_wen}, 32'd0);
    set_ex(7'h6F, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h800, 32'h1000); #1;
    chk("jal_target", branch_target, 32'h1800);
    chk("jal_result", ex_result, 32'h1004);
    clear_stages();

    // Load-use replay.
    set_ex(7'h03, 3'b010, 7'h00, 5'd5, 5'd7, 5'd0, 32'h1000, 32'h0, 32'd8, 32'h0);
    id_instr = 32'h0002_8333; #1;
    chk("lu_fsel",   {30'd0, fetch_sel}, 32'd2);
    chk("lu_nops",   {30'd0, nop_fetch, nop_dec}, 32'd1);
    chk("lu_addr",   ex_result, 32'h1008);
    ex_rd = 5'd8; id_instr = 32'h1234_52B7; #1;
    chk("lu_lui_none", {30'd0, fetch_sel}, 32'd0);
    ex_rd = 5'd5; id_instr = 32'h0050_0093; #1;
    chk("lu_opi_rs2_none", {31'd0, nop_dec}, 32'd0);
    ex_rd = 5'd0; id_instr = 32'h0000_0033; #1;
    chk("lu_x0_none", {31'd0, nop_dec}, 32'd0);
    id_instr = 32'h0002_8333;
    set_ex(7'h33, 3'b000, 7'h00, 5'd6, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    mem_opcode = 7'h03; mem_funct3 = 3'b010; mem_rd = 5'd5; mem_result = 32'h55; #1;
    chk("lu_fwd_result", ex_result, 32'h55);
    chk("lu_fwd_fsel", {30'd0, fetch_sel}, 32'd0);
    chk("mem_lw", {26'd0, mem_load, mem_store, mem_size, mem_sign}, {26'd0, 1'b1, 1'b0, 3'b100, 1'b1});

    // Memory controls.
    mem_funct3 = 3'b100; #1;
    chk("mem_lbu", {26'd0, mem_load, mem_store, mem_size, mem_sign}, {26'd0, 1'b1, 1'b0, 3'b001, 1'b0});
    mem_opcode = 7'h23; mem_funct3 = 3'b001; #1;
    chk("mem_sh", {26'd0, mem_load, mem_store, mem_size, mem_sign}, {26'd0, 1'b0, 1'b1, 3'b010, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
